mm_job_sequencer: RTL

- Sequences one matrix-multiply job from start to host-visible completion.
- On a command carrying a destination line address, it pulses start to the Multi_top datapath and waits for done, with a timeout.
- It then reads out the 64 result words, packs them 16 per 512-bit line and issues four CCI-P line writes.
- It finishes with a status line and waits for every write response before accepting the next job. It sits between the AFU CSR/FSM glue and the c1 write channel.

---
 rtl/mm_job_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mm_job_sequencer.sv
// Runs one matrix-multiply job: start, wait for done, stream the result
// words out as CCI-P line writes, post a status line, then drain responses.
module mm_job_sequencer #(
  parameter int N_WORDS        = 64,
  parameter int WORD_W         = 32,
  parameter int ADDR_W         = 42,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_dst_addr,
  output logic              mm_start,
  input  logic              mm_done,
  output logic [5:0]        z_rd_addr,
  input  logic [WORD_W-1:0] z_dout,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [511:0]      wr_data,
  input  logic              wr_almfull,
  input  logic              wr_rsp_valid,
  output logic              busy,
  output logic              job_done,
  output logic [1:0]        status
);

  localparam int LINE_W = 512;
  localparam int WPL    = LINE_W / WORD_W;
  localparam int NL     = N_WORDS / WPL;
  localparam int SW     = $clog2(WPL);

  localparam logic [SW:0]       REQ_MAX  = (SW+1)'(WPL);
  localparam logic [SW-1:0]     SLOT_END = SW'(WPL - 1);
  localparam logic [ADDR_W-1:0] LINE_END = ADDR_W'(NL - 1);
  localparam logic [ADDR_W-1:0] STAT_OFS = ADDR_W'(NL);
  localparam logic [63:0]       TO_LAST  = 64'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_FILL,
    S_ISSUE,
    S_STAT,
    S_RSP
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [63:0]         r_cyc;
  logic [5:0]          r_addr;
  logic [SW:0]         r_req;
  logic                r_pend;
  logic [SW-1:0]       r_slot;
  logic [ADDR_W-1:0]   r_line;
  logic [LINE_W-1:0]   r_buf;
  logic [1:0]          r_code;
  logic [7:0]          r_out;
  logic                r_cmd_ready;
  logic                r_mm_start;
  logic                r_wr_valid;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [LINE_W-1:0]   r_wr_data;
  logic                r_busy;
  logic                r_job_done;
  logic [1:0]          r_status;

  logic w_issue;
  logic w_rsp;

  assign w_issue = ((r_state == S_ISSUE) || (r_state == S_STAT))
                   && !wr_almfull;
  assign w_rsp   = wr_rsp_valid && (r_out != 8'd0);

  assign cmd_ready = r_cmd_ready;
  assign mm_start  = r_mm_start;
  assign z_rd_addr = r_addr;
  assign wr_valid  = r_wr_valid;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign job_done  = r_job_done;
  assign status    = r_status;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_cyc       <= '0;
      r_addr      <= '0;
      r_req       <= '0;
      r_pend      <= 1'b0;
      r_slot      <= '0;
      r_line      <= '0;
      r_buf       <= '0;
      r_code      <= 2'd0;
      r_out       <= 8'd0;
      r_cmd_ready <= 1'b1;
      r_mm_start  <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_job_done  <= 1'b0;
      r_status    <= 2'd0;
    end else begin
      r_mm_start <= 1'b0;
      r_wr_valid <= 1'b0;
      r_job_done <= 1'b0;

      if (w_issue && !w_rsp)
        r_out <= r_out + 8'd1;
      else if (!w_issue && w_rsp)
        r_out <= r_out - 8'd1;

      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_base      <= cmd_dst_addr;
            r_cyc       <= '0;
            r_line      <= '0;
            r_addr      <= '0;
            r_code      <= 2'd0;
            r_mm_start  <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (mm_done) begin
            r_addr  <= '0;
            r_req   <= '0;
            r_pend  <= 1'b0;
            r_slot  <= '0;
            r_state <= S_FILL;
          end else if (r_cyc == TO_LAST) begin
            r_code  <= 2'd2;
            r_state <= S_STAT;
          end else if (r_cyc != '1) begin
            r_cyc <= r_cyc + 64'd1;
          end
        end
        S_FILL: begin
          // read data trails its address by one cycle
          if (r_req != REQ_MAX) begin
            r_addr <= r_addr + 6'd1;
            r_req  <= r_req + 1'b1;
          end
          r_pend <= (r_req != REQ_MAX);
          if (r_pend) begin
            r_buf[r_slot*WORD_W +: WORD_W] <= z_dout;
            r_slot <= r_slot + 1'b1;
            if (r_slot == SLOT_END)
              r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!wr_almfull) begin
            r_wr_valid <= 1'b1;
            r_wr_addr  <= r_base + r_line;
            r_wr_data  <= r_buf;
            r_line     <= r_line + 1'b1;
            if (r_line == LINE_END) begin
              r_code  <= 2'd1;
              r_state <= S_STAT;
            end else begin
              r_req   <= '0;
              r_state <= S_FILL;
            end
          end
        end
        S_STAT: begin
          if (!wr_almfull) begin
            r_wr_valid <= 1'b1;
            r_wr_addr  <= r_base + STAT_OFS;
            r_wr_data  <= {384'd0, r_cyc, 62'd0, r_code};
            r_state    <= S_RSP;
          end
        end
        S_RSP: begin
          if (r_out == 8'd0) begin
            r_job_done  <= 1'b1;
            r_status    <= r_code;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
